// File: rtl/absorb_block_packer.sv
// Packs a 32-bit valid/ready word stream into NUMBLOCKS-word blocks with 10* byte padding.
// Define PACK_BYTE_SWAP_EN to byte-reverse each incoming word (big-endian source).
module absorb_block_packer #(
    parameter int BWIDTH    = 32,
    parameter int NUMBLOCKS = 4,
    parameter int CNTWIDTH  = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [BWIDTH-1:0]           s_data,
    input  logic                        s_valid,
    input  logic                        s_last,
    input  logic [2:0]                  s_bytes,
    output logic                        s_ready,
    input  logic [1:0]                  domain_in,
    output logic [BWIDTH*NUMBLOCKS-1:0] blocks,
    output logic                        finalize,
    output logic [1:0]                  domain,
    output logic                        en,
    input  logic                        absorb_done,
    output logic [CNTWIDTH-1:0]         blk_count
);

    localparam int NBYTES = BWIDTH / 8;
    localparam int IDXW   = (NUMBLOCKS > 1) ? $clog2(NUMBLOCKS) : 1;
    localparam logic [2:0] FULL_BYTES = 3'(NBYTES);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUMBLOCKS - 1);

    typedef enum logic [1:0] {
        S_FILL,
        S_PAD,
        S_ISSUE,
        S_WAIT
    } state_t;

    state_t                           state_q, state_d;
    logic [IDXW-1:0]                  idx_q, idx_d;
    logic [NUMBLOCKS-1:0][BWIDTH-1:0] blk_q, blk_d;
    logic                             finalize_q, finalize_d;
    logic [1:0]                       domain_q, domain_d;
    logic                             en_q, en_d;
    logic                             s_ready_q, s_ready_d;
    logic [CNTWIDTH-1:0]              cnt_q, cnt_d;
    logic                             pending_q, pending_d;
    logic                             first_q, first_d;

    logic              accept;
    logic [BWIDTH-1:0] word_in;
    logic [BWIDTH-1:0] pad_word;
    logic [2:0]        nbytes;

    assign accept = s_valid & s_ready_q;
    assign nbytes = (s_bytes > FULL_BYTES) ? FULL_BYTES : s_bytes;

    always_comb begin
`ifdef PACK_BYTE_SWAP_EN
        word_in = '0;
        for (int b = 0; b < NBYTES; b++) begin
            word_in[b*8 +: 8] = s_data[(NBYTES-1-b)*8 +: 8];
        end
`else
        word_in = s_data;
`endif
    end

    // Keep the valid bytes, place the 0x01 marker right after them, zero the rest.
    always_comb begin
        pad_word = '0;
        for (int b = 0; b < NBYTES; b++) begin
            if (3'(b) < nbytes) begin
                pad_word[b*8 +: 8] = word_in[b*8 +: 8];
            end else if (3'(b) == nbytes) begin
                pad_word[b*8 +: 8] = 8'h01;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        blk_d      = blk_q;
        finalize_d = finalize_q;
        domain_d   = domain_q;
        cnt_d      = cnt_q;
        pending_d  = pending_q;
        first_d    = first_q;

        case (state_q)
            S_FILL: begin
                if (accept) begin
                    if (first_q) begin
                        domain_d = domain_in;
                    end
                    first_d = s_last;
                    if (s_last && (nbytes != FULL_BYTES)) begin
                        blk_d[idx_q] = pad_word;
                        for (int k = 0; k < NUMBLOCKS; k++) begin
                            if (k > int'(idx_q)) begin
                                blk_d[k] = '0;
                            end
                        end
                        finalize_d = 1'b1;
                        state_d    = S_ISSUE;
                    end else begin
                        blk_d[idx_q] = word_in;
                        if (idx_q == LAST_IDX) begin
                            // A full final word in the last slot needs a whole padding block next.
                            finalize_d = 1'b0;
                            pending_d  = s_last;
                            state_d    = S_ISSUE;
                        end else begin
                            idx_d = idx_q + 1'b1;
                            if (s_last) begin
                                state_d = S_PAD;
                            end
                        end
                    end
                end
            end
            S_PAD: begin
                blk_d[idx_q] = BWIDTH'(1);
                for (int k = 0; k < NUMBLOCKS; k++) begin
                    if (k > int'(idx_q)) begin
                        blk_d[k] = '0;
                    end
                end
                finalize_d = 1'b1;
                pending_d  = 1'b0;
                state_d    = S_ISSUE;
            end
            S_ISSUE: begin
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (absorb_done) begin
                    blk_d   = '0;
                    idx_d   = '0;
                    state_d = pending_q ? S_PAD : S_FILL;
                end
            end
            default: begin
                state_d = S_FILL;
            end
        endcase

        en_d      = (state_q == S_ISSUE);
        s_ready_d = (state_d == S_FILL);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_FILL;
            idx_q      <= '0;
            blk_q      <= '0;
            finalize_q <= 1'b0;
            domain_q   <= 2'd0;
            en_q       <= 1'b0;
            s_ready_q  <= 1'b0;
            cnt_q      <= '0;
            pending_q  <= 1'b0;
            first_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            blk_q      <= blk_d;
            finalize_q <= finalize_d;
            domain_q   <= domain_d;
            en_q       <= en_d;
            s_ready_q  <= s_ready_d;
            cnt_q      <= cnt_d;
            pending_q  <= pending_d;
            first_q    <= first_d;
        end
    end

    assign s_ready   = s_ready_q;
    assign blocks    = blk_q;
    assign finalize  = finalize_q;
    assign domain    = domain_q;
    assign en        = en_q;
    assign blk_count = cnt_q;

endmodule
